// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
package clk_div_pkg;

  localparam int unsigned CNT_W_DEF = 8;
  localparam int unsigned DIV_MIN   = 2;

  // Number of high cycles in a period of n clocks (ceil(n/2)).
  function automatic int unsigned hi_count(input int unsigned n);
    return (n + 1) >> 1;
  endfunction

endpackage

// File: rtl/clk_div_ctr.sv
// Period counter, wrap detect and registered div_clk/div_tick generation.
// act is the divisor of the running period; act_nxt governs the period that starts on a wrap.
module clk_div_ctr
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W     = CNT_W_DEF,
  parameter int unsigned DIV_RESET = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic [CNT_W-1:0] act,
  input  logic [CNT_W-1:0] act_nxt,
  output logic             wrap_c,
  output logic             div_clk,
  output logic             div_tick
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt_c;
  logic [CNT_W-1:0] hi_c;

  // A forced resync wraps exactly like a natural end of period.
  always_comb begin
    wrap_c    = en && (sync || (cnt == act - CNT_W'(1)));
    cnt_nxt_c = wrap_c ? '0 : cnt + CNT_W'(1);
    hi_c      = CNT_W'(hi_count(32'(act_nxt)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= CNT_W'(DIV_RESET - 1);
      div_clk  <= 1'b0;
      div_tick <= 1'b0;
    end else if (en) begin
      cnt      <= cnt_nxt_c;
      div_clk  <= (cnt_nxt_c < hi_c);
      div_tick <= wrap_c;
    end else begin
      div_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with glitch-free divisor reload.
// Optional CLK_DIV_PHASE_EN adds a phase_sync input that forces a period restart.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W     = CNT_W_DEF,
  parameter int unsigned DIV_RESET = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
`ifdef CLK_DIV_PHASE_EN
  input  logic             phase_sync,
`endif
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_value,
  output logic             div_ack,
  output logic             div_err,
  output logic             div_clk,
  output logic             div_tick,
  output logic [CNT_W-1:0] cur_div
);

  logic [CNT_W-1:0] act;
  logic [CNT_W-1:0] pend;
  logic             pend_vld;
  logic [CNT_W-1:0] act_nxt_c;
  logic             wrap_c;
  logic             sync_c;
  logic             load_ok_c;

`ifdef CLK_DIV_PHASE_EN
  assign sync_c = phase_sync;
`else
  assign sync_c = 1'b0;
`endif

  assign load_ok_c = (div_value >= CNT_W'(DIV_MIN));
  // The wrap consumes the pending value held before this edge.
  assign act_nxt_c = (wrap_c && pend_vld) ? pend : act;
  assign cur_div   = act;

  always_ff @(posedge clk) begin
    if (rst) begin
      act      <= CNT_W'(DIV_RESET);
      pend     <= '0;
      pend_vld <= 1'b0;
      div_ack  <= 1'b0;
      div_err  <= 1'b0;
    end else begin
      div_ack <= div_load && load_ok_c;
      div_err <= div_load && !load_ok_c;
      act     <= act_nxt_c;
      if (div_load && load_ok_c) begin
        pend     <= div_value;
        pend_vld <= 1'b1;
      end else if (wrap_c) begin
        pend_vld <= 1'b0;
      end
    end
  end

  clk_div_ctr #(
    .CNT_W     (CNT_W),
    .DIV_RESET (DIV_RESET)
  ) u_ctr (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sync     (sync_c),
    .act      (act),
    .act_nxt  (act_nxt_c),
    .wrap_c   (wrap_c),
    .div_clk  (div_clk),
    .div_tick (div_tick)
  );

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed self-checking bench for clk_div_prog; each observation is
// {div_clk, div_tick, div_ack, div_err, cur_div} sampled 1 time unit after the edge.
module tb_clk_div_prog;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       div_load;
  logic [7:0] div_value;
  logic       div_ack;
  logic       div_err;
  logic       div_clk;
  logic       div_tick;
  logic [7:0] cur_div;
`ifdef CLK_DIV_PHASE_EN
  logic       phase_sync = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  clk_div_prog dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
`ifdef CLK_DIV_PHASE_EN
    .phase_sync (phase_sync),
`endif
    .div_load   (div_load),
    .div_value  (div_value),
    .div_ack    (div_ack),
    .div_err    (div_err),
    .div_clk    (div_clk),
    .div_tick   (div_tick),
    .cur_div    (cur_div)
  );

  function automatic logic [11:0] obs();
    return {div_clk, div_tick, div_ack, div_err, cur_div};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; div_load = 1'b0; div_value = 8'd0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    if (obs() !== {4'b0000, 8'd2}) begin
      n_bad++;
      $display("FAIL reset: got %h want %h", obs(), {4'b0000, 8'd2});
    end
    n_cmp++;
  endtask

  task automatic test_div2();
    logic [11:0] exp;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      exp = (i % 2 == 0) ? {4'b1100, 8'd2} : {4'b0000, 8'd2};
      if (obs() !== exp) begin
        n_bad++;
        $display("FAIL div2[%0d]: got %h want %h", i, obs(), exp);
      end
      n_cmp++;
    end
  endtask

  task automatic test_load5();
    logic [9:0]  clk_pat;
    logic [9:0]  tick_pat;
    logic [11:0] exp;
    clk_pat  = 10'b1110011100;
    tick_pat = 10'b1000010000;
    do_reset();
    en = 1'b1;
    step();
    div_load = 1'b1; div_value = 8'd5;
    step();
    div_load = 1'b0;
    if (obs() !== {4'b0010, 8'd2}) begin
      n_bad++;
      $display("FAIL load5_ack: got %h want %h", obs(), {4'b0010, 8'd2});
    end
    n_cmp++;
    for (int i = 0; i < 10; i++) begin
      step();
      exp = {clk_pat[9-i], tick_pat[9-i], 2'b00, 8'd5};
      if (obs() !== exp) begin
        n_bad++;
        $display("FAIL load5[%0d]: got %h want %h", i, obs(), exp);
      end
      n_cmp++;
    end
  endtask

  task automatic test_load_err();
    logic [11:0] exp_tab [4];
    exp_tab[0] = {4'b0001, 8'd2};
    exp_tab[1] = {4'b1101, 8'd2};
    exp_tab[2] = {4'b0000, 8'd2};
    exp_tab[3] = {4'b1100, 8'd2};
    do_reset();
    en = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      div_load  = (i < 2);
      div_value = 8'(i);
      step();
      if (obs() !== exp_tab[i]) begin
        n_bad++;
        $display("FAIL load_err[%0d]: got %h want %h", i, obs(), exp_tab[i]);
      end
      n_cmp++;
    end
    div_load = 1'b0;
  endtask

  task automatic test_load_on_wrap();
    logic [6:0]  clk_pat;
    logic [6:0]  tick_pat;
    logic [11:0] exp;
    clk_pat  = 7'b1110001;
    tick_pat = 7'b0000001;
    do_reset();
    en = 1'b1;
    step();
    step();
    div_load = 1'b1; div_value = 8'd3;
    step();
    if (obs() !== {4'b1110, 8'd2}) begin
      n_bad++;
      $display("FAIL wrap_load3: got %h want %h", obs(), {4'b1110, 8'd2});
    end
    n_cmp++;
    div_value = 8'd7;
    step();
    div_load = 1'b0;
    if (obs() !== {4'b0010, 8'd2}) begin
      n_bad++;
      $display("FAIL wrap_load7: got %h want %h", obs(), {4'b0010, 8'd2});
    end
    n_cmp++;
    step();
    if (obs() !== {4'b1100, 8'd7}) begin
      n_bad++;
      $display("FAIL wrap_apply7: got %h want %h", obs(), {4'b1100, 8'd7});
    end
    n_cmp++;
    for (int i = 0; i < 7; i++) begin
      step();
      exp = {clk_pat[6-i], tick_pat[6-i], 2'b00, 8'd7};
      if (obs() !== exp) begin
        n_bad++;
        $display("FAIL wrap_per7[%0d]: got %h want %h", i, obs(), exp);
      end
      n_cmp++;
    end
  endtask

  task automatic test_enable_hold();
    logic [9:0]  en_pat;
    logic [9:0]  clk_pat;
    logic [9:0]  tick_pat;
    logic [11:0] exp;
    en_pat   = 10'b1100001111;
    clk_pat  = 10'b1111110001;
    tick_pat = 10'b0000000001;
    do_reset();
    en = 1'b1;
    div_load = 1'b1; div_value = 8'd6;
    step();
    div_load = 1'b0;
    step();
    step();
    if (obs() !== {4'b1100, 8'd6}) begin
      n_bad++;
      $display("FAIL hold_start6: got %h want %h", obs(), {4'b1100, 8'd6});
    end
    n_cmp++;
    for (int i = 0; i < 10; i++) begin
      en = en_pat[9-i];
      step();
      exp = {clk_pat[9-i], tick_pat[9-i], 2'b00, 8'd6};
      if (obs() !== exp) begin
        n_bad++;
        $display("FAIL hold[%0d]: got %h want %h", i, obs(), exp);
      end
      n_cmp++;
    end
  endtask

  task automatic test_reset_pending();
    logic [11:0] exp_tab [3];
    exp_tab[0] = {4'b1100, 8'd2};
    exp_tab[1] = {4'b0000, 8'd2};
    exp_tab[2] = {4'b1100, 8'd2};
    do_reset();
    en = 1'b1;
    step();
    div_load = 1'b1; div_value = 8'd9;
    step();
    div_load = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    if (obs() !== {4'b0000, 8'd2}) begin
      n_bad++;
      $display("FAIL rst_pend: got %h want %h", obs(), {4'b0000, 8'd2});
    end
    n_cmp++;
    for (int i = 0; i < 3; i++) begin
      step();
      if (obs() !== exp_tab[i]) begin
        n_bad++;
        $display("FAIL rst_pend_run[%0d]: got %h want %h", i, obs(), exp_tab[i]);
      end
      n_cmp++;
    end
  endtask

`ifdef CLK_DIV_PHASE_EN
  task automatic test_phase_sync();
    logic [7:0]  clk_pat;
    logic [7:0]  tick_pat;
    logic [11:0] exp;
    clk_pat  = 8'b11100001;
    tick_pat = 8'b00000001;
    do_reset();
    en = 1'b1;
    div_load = 1'b1; div_value = 8'd8;
    step();
    div_load = 1'b0;
    step();
    step();
    step();
    step();
    phase_sync = 1'b1;
    step();
    phase_sync = 1'b0;
    if (obs() !== {4'b1100, 8'd8}) begin
      n_bad++;
      $display("FAIL phase_wrap: got %h want %h", obs(), {4'b1100, 8'd8});
    end
    n_cmp++;
    for (int i = 0; i < 8; i++) begin
      step();
      exp = {clk_pat[7-i], tick_pat[7-i], 2'b00, 8'd8};
      if (obs() !== exp) begin
        n_bad++;
        $display("FAIL phase_per8[%0d]: got %h want %h", i, obs(), exp);
      end
      n_cmp++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_div2();
    test_load5();
    test_load_err();
    test_load_on_wrap();
    test_enable_hold();
    test_reset_pending();
`ifdef CLK_DIV_PHASE_EN
    test_phase_sync();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
